mdu: RTL
========

# mdu

Multiply/divide unit in the E stage of the P7 pipeline; the execution-side responder to the decoder's `MDUOp`/`MDUStart` outputs. It performs `mult`/`multu`/`div`/`divu` as fixed-latency multi-cycle operations with a `Busy` handshake that the hazard unit stalls on. It owns the architectural HI/LO registers, services `mthi`/`mtlo` writes and `mfhi`/`mflo` reads, and drops any request flagged by the exception logic.

## Interface
- `MULT_CYCLES`, 5, cycles a `mult`/`multu` occupies after its start cycle (≥1).
- `DIV_CYCLES`, 10, cycles a `div`/`divu` occupies after its start cycle (≥1).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `MDUOp`  in  5  mult=0, multu=1, div=2, divu=3, mfhi=4, mflo=5, mthi=6, mtlo=7; other values act as no-op.
- `MDUStart`  in  1  start pulse for mult/multu/div/divu.
- `Req`  in  1  exception/interrupt request in flight; suppresses every state-changing action this cycle.
- `A`  in  32  rs operand (forwarded).
- `B`  in  32  rt operand (forwarded).
- `Busy`  out  1  `MDUStart | (cnt != 0)`, combinational.
- `Out`  out  32  `HI` when MDUOp=mfhi, `LO` when MDUOp=mflo, otherwise 0; combinational.
- `HI`, `LO`  out  32 each  architectural registers.

## Operation
- State: `HI`, `LO`, result staging `tHI`/`tLO`, and a down-counter `cnt`. Two states: IDLE (`cnt==0`) and BUSY (`cnt!=0`).
- Reset (`reset==0`, asynchronous): `HI`, `LO`, `tHI`, `tLO`, `cnt` all 0. `Busy` and `Out` then follow their equations, so `Busy=MDUStart` and `Out=0` unless MDUOp=mfhi/mflo.
- Accepting a start requires IDLE, `MDUStart=1`, `Req=0`, and MDUOp in 0..3. At the edge:
  - load `cnt` with MULT_CYCLES for mult/multu, DIV_CYCLES for div/divu;
  - compute the result from the current `A`/`B` into `tHI`/`tLO`. Later operand changes have no effect.
- mult: 64-bit signed product `{tHI,tLO}`. multu: unsigned product.
- div: `tLO = $signed(A)/$signed(B)`, truncated toward zero. `tHI` is the remainder and carries the dividend's sign. For 0x80000000/0xFFFFFFFF: `tLO=0x80000000`, `tHI=0`.
- divu: unsigned quotient and remainder.
- Divide by zero (`B==0`, div or divu): the counter runs normally, but `tHI`/`tLO` are loaded with the current `HI`/`LO`, so HI/LO are unchanged at the end.
- BUSY: `cnt` decrements each edge. On the edge where `cnt==1`, `HI<=tHI`, `LO<=tLO`, `cnt<=0`.
- mthi/mtlo: in IDLE with `Req=0`, `HI<=A` (mthi) or `LO<=A` (mtlo) at the edge. They are ignored while BUSY; the controller stalls them on `Busy`.
- `MDUStart` while BUSY: ignored. The controller guarantees this does not occur, and the unit must not corrupt the in-flight operation.
- `Req=1`: start, mthi and mtlo are all ignored. An operation already in BUSY runs to completion, because it belongs to an older instruction.
- mfhi/mflo have no side effects. `Out` shows the registered HI/LO, not `tHI`/`tLO`.

## Timing
- Start accepted in cycle N: `Busy=1` in cycles N..N+MULT_CYCLES (mult) or N..N+DIV_CYCLES (div), with `cnt` nonzero from N+1.
- HI/LO take the new value at the edge ending cycle N+MULT_CYCLES (or N+DIV_CYCLES), and are readable via `Out` from the following cycle.
- `Busy` deasserts in the same cycle HI/LO become valid. A start in that cycle is accepted (back-to-back issue).
- mthi/mtlo in cycle N: new HI/LO are visible in cycle N+1.
- Reset mid-operation: `cnt=0` immediately and the operation is abandoned. No partial HI/LO update.

## Test plan
- Multiply latency and results: MDUStart with mult, A=0xFFFFFFFF, B=2. Required: `Busy` high 6 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. Repeat with multu; required: HI=0x00000001, LO=0xFFFFFFFE.
- Signed and unsigned divide: div with A=0xFFFFFFF9 (-7), B=2. Required: `Busy` high 11 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with A=7, B=2; required: LO=3, HI=1.
- Divide by zero and overflow: mthi 0x1234, mtlo 0x5678, then div with B=0. Required: after 11 cycles HI=0x1234, LO=0x5678. div 0x80000000/0xFFFFFFFF; required: LO=0x80000000, HI=0.
- Moves, reads and Req suppression:
  - mtlo A=0xABCD, then mflo; required: `Out=0xABCD` in the next cycle.
  - mthi with `Req=1`; required: HI unchanged.
  - mult start with `Req=1`; required: `Busy` high only in that cycle, HI/LO unchanged.
- Reset and back-to-back:
  - Start divu, pull `reset` low at cycle N+4. Required: `Busy=0`, HI=LO=0 immediately; HI/LO stay 0 after release.
  - Issue a second mult in the cycle `Busy` drops. Required: it is accepted, with results after 5 further cycles.

Source files
------------

// File: rtl/mdu_if.sv
// Handshake and data bundle between the E-stage controller and the multiply/divide unit.
interface mdu_if;
  logic [4:0]  MDUOp;
  logic        MDUStart;
  logic        Req;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] Out;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output MDUOp, MDUStart, Req, A, B, input Busy, Out, HI, LO);
  modport slave  (input MDUOp, MDUStart, Req, A, B, output Busy, Out, HI, LO);
endinterface

// File: rtl/mdu.sv
// Fixed-latency multiply/divide unit owning HI/LO; results are staged at start
// and committed to HI/LO when the down-counter expires.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);
  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam int unsigned OP_W       = 5;

  localparam logic [OP_W-1:0] OP_MULT  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_MULTU = OP_W'(1);
  localparam logic [OP_W-1:0] OP_DIV   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_MFHI  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_MFLO  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_MTHI  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_MTLO  = OP_W'(7);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d, thi_q, thi_d, tlo_q, tlo_d;

  logic signed [63:0] a_sx, b_sx, prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        quot_s, rem_s, quot_u, rem_u;

  // Arithmetic datapath on the live operands; only sampled on an accepted start.
  always_comb begin
    a_sx   = {{32{bus.A[31]}}, bus.A};
    b_sx   = {{32{bus.B[31]}}, bus.B};
    prod_s = a_sx * b_sx;
    prod_u = {32'd0, bus.A} * {32'd0, bus.B};
    quot_s = '0;
    rem_s  = '0;
    quot_u = '0;
    rem_u  = '0;
    if (bus.B != 32'd0) begin
      quot_u = bus.A / bus.B;
      rem_u  = bus.A % bus.B;
      // The one signed quotient that does not fit wraps back to the dividend.
      if (bus.A == 32'h8000_0000 && bus.B == 32'hFFFF_FFFF) begin
        quot_s = bus.A;
        rem_s  = 32'd0;
      end else begin
        quot_s = 32'($signed(bus.A) / $signed(bus.B));
        rem_s  = 32'($signed(bus.A) % $signed(bus.B));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      thi_q   <= '0;
      tlo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      thi_q   <= thi_d;
      tlo_q   <= tlo_d;
    end
  end

  // Next-state: accept starts/moves in IDLE, count down and commit in BUSY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    thi_d   = thi_q;
    tlo_d   = tlo_q;
    unique case (state_q)
      IDLE: begin
        if (!bus.Req) begin
          if (bus.MDUStart && bus.MDUOp <= OP_DIVU) begin
            state_d = BUSY;
            unique case (bus.MDUOp)
              OP_MULT:  begin cnt_d = CNT_W'(MULT_CYCLES); {thi_d, tlo_d} = prod_s; end
              OP_MULTU: begin cnt_d = CNT_W'(MULT_CYCLES); {thi_d, tlo_d} = prod_u; end
              OP_DIV:   begin cnt_d = CNT_W'(DIV_CYCLES);  thi_d = rem_s; tlo_d = quot_s; end
              default:  begin cnt_d = CNT_W'(DIV_CYCLES);  thi_d = rem_u; tlo_d = quot_u; end
            endcase
            // Divide by zero leaves HI/LO as they were once the op retires.
            if (bus.MDUOp >= OP_DIV && bus.B == 32'd0) begin
              thi_d = hi_q;
              tlo_d = lo_q;
            end
          end else if (bus.MDUOp == OP_MTHI) begin
            hi_d = bus.A;
          end else if (bus.MDUOp == OP_MTLO) begin
            lo_d = bus.A;
          end
        end
      end
      BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          hi_d    = thi_q;
          lo_d    = tlo_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.Out = 32'd0;
    if (bus.MDUOp == OP_MFHI) bus.Out = hi_q;
    else if (bus.MDUOp == OP_MFLO) bus.Out = lo_q;
  end

  assign bus.Busy = bus.MDUStart | (state_q == BUSY);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
endmodule
